// File: rtl/cross_credit_consumer_pkg.sv
// Shared types and configuration limits for the consumer-side credit gate.
package cross_credit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } gate_state_t;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_LOWER_SKIP = 0;
    localparam int DEFAULT_REQ_WIDTH  = 4;

    // A request must fit in half the counter range so the wrap test on diff stays unambiguous.
    function automatic bit widths_ok(int width, int lower_skip, int req_width);
        return (width >= 2) && (req_width >= 1) && (req_width <= width - 1) &&
               (lower_skip >= 0) && (lower_skip < width);
    endfunction

endpackage

// File: rtl/cross_credit_consumer_if.sv
// Request/grant, availability and return-command signals of the credit gate.
interface cross_credit_consumer_if
    import cross_credit_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int LOWER_SKIP = DEFAULT_LOWER_SKIP,
    parameter int REQ_WIDTH  = DEFAULT_REQ_WIDTH
) ();

    logic [WIDTH-1:LOWER_SKIP] remote_cnt;
    logic                      req_valid;
    logic [REQ_WIDTH-1:0]      req_len;
    logic                      req_ready;
    logic                      grant_valid;
    logic [WIDTH-1:0]          grant_base;
    logic [WIDTH-1:0]          avail;
    logic                      underflow;
    logic                      cmdvalid;
    logic                      cmdinc;

    modport master (
        output remote_cnt, req_valid, req_len,
        input  req_ready, grant_valid, grant_base, avail, underflow, cmdvalid, cmdinc
    );

    modport slave (
        input  remote_cnt, req_valid, req_len,
        output req_ready, grant_valid, grant_base, avail, underflow, cmdvalid, cmdinc
    );

endinterface

// File: rtl/cross_credit_consumer_credit_return_drain.sv
// Accumulates granted units and returns them to the producer one unit per cycle.
module credit_return_drain #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_valid,
    input  logic [WIDTH-1:0] add_len,
    output logic             cmdvalid,
    output logic             cmdinc
);

    logic [WIDTH-1:0] ret_pending;
    logic [WIDTH-1:0] ret_next;

    // Add and drain may coincide; outstanding returns never exceed half the range.
    always_comb begin
        ret_next = ret_pending;
        if (add_valid) begin
            ret_next = ret_next + add_len;
        end
        if (cmdvalid) begin
            ret_next = ret_next - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ret_pending <= '0;
        end else begin
            ret_pending <= ret_next;
        end
    end

    assign cmdvalid = (ret_pending != '0);
    assign cmdinc   = 1'b1;

endmodule

// File: rtl/cross_credit_consumer.sv
// Consumer-side credit gate: grants variable-length requests against the synchronized
// producer count and hands consumed units back through a one-unit return stream.
module cross_credit_consumer
    import cross_credit_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int LOWER_SKIP = DEFAULT_LOWER_SKIP,
    parameter int REQ_WIDTH  = DEFAULT_REQ_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    cross_credit_consumer_if.slave bus
);

    if (!widths_ok(WIDTH, LOWER_SKIP, REQ_WIDTH)) begin : g_bad_cfg
        $error("cross_credit_consumer: unsupported WIDTH/LOWER_SKIP/REQ_WIDTH combination");
    end

    gate_state_t          state;
    gate_state_t          state_next;
    logic                 grant_fire;
    logic [REQ_WIDTH-1:0] len_r;
    logic [WIDTH-1:0]     len_ext;
    logic [WIDTH-1:0]     consumed;
    logic [WIDTH-1:0]     remote_full;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     avail_r;
    logic [WIDTH-1:0]     grant_base_r;
    logic                 underflow_r;

    // Dropped low bits read as zero, so availability is floored, never overstated.
    assign remote_full = WIDTH'(bus.remote_cnt) << LOWER_SKIP;
    assign diff        = remote_full - consumed;
    assign len_ext     = WIDTH'(len_r);

    always_comb begin
        state_next = state;
        grant_fire = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (avail_r >= len_ext) begin
                    grant_fire = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A negative diff means the producer count moved behind us; hold off and flag it for good.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r        <= '0;
            consumed     <= '0;
            grant_base_r <= '0;
            avail_r      <= '0;
            underflow_r  <= 1'b0;
        end else begin
            if (diff[WIDTH-1]) begin
                avail_r     <= '0;
                underflow_r <= 1'b1;
            end else begin
                avail_r <= diff;
            end
            if (state == IDLE && bus.req_valid) begin
                len_r <= bus.req_len;
            end
            if (grant_fire) begin
                consumed     <= consumed + len_ext;
                grant_base_r <= consumed;
            end
        end
    end

    credit_return_drain #(
        .WIDTH(WIDTH)
    ) u_drain (
        .clk      (clk),
        .rst      (rst),
        .add_valid(grant_fire),
        .add_len  (len_ext),
        .cmdvalid (bus.cmdvalid),
        .cmdinc   (bus.cmdinc)
    );

    assign bus.req_ready   = (state == DONE);
    assign bus.grant_valid = (state == DONE);
    assign bus.grant_base  = grant_base_r;
    assign bus.avail       = avail_r;
    assign bus.underflow   = underflow_r;

endmodule

// File: tb/tb_cross_credit_consumer.sv
// Bench for cross_credit_consumer: one instance with full-resolution count, one with LOWER_SKIP=2.
module tb_cross_credit_consumer;

    int compared   = 0;
    int mismatched = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [7:0] remote_a = '0;
    logic [5:0] remote_b = '0;
    logic       vld    [2];
    logic [3:0] len_in [2];

    logic       ready_o  [2];
    logic       gvalid_o [2];
    logic [7:0] base_o   [2];
    logic [7:0] avail_o  [2];
    logic       under_o  [2];
    logic       cmd_o    [2];
    logic       cmdinc_o [2];

    cross_credit_consumer_if #(.WIDTH(8), .LOWER_SKIP(0), .REQ_WIDTH(4)) bus_a ();
    cross_credit_consumer_if #(.WIDTH(8), .LOWER_SKIP(2), .REQ_WIDTH(4)) bus_b ();

    cross_credit_consumer #(.WIDTH(8), .LOWER_SKIP(0), .REQ_WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    cross_credit_consumer #(.WIDTH(8), .LOWER_SKIP(2), .REQ_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    assign bus_a.remote_cnt = remote_a;
    assign bus_a.req_valid  = vld[0];
    assign bus_a.req_len    = len_in[0];
    assign bus_b.remote_cnt = remote_b;
    assign bus_b.req_valid  = vld[1];
    assign bus_b.req_len    = len_in[1];

    assign ready_o[0]  = bus_a.req_ready;
    assign gvalid_o[0] = bus_a.grant_valid;
    assign base_o[0]   = bus_a.grant_base;
    assign avail_o[0]  = bus_a.avail;
    assign under_o[0]  = bus_a.underflow;
    assign cmd_o[0]    = bus_a.cmdvalid;
    assign cmdinc_o[0] = bus_a.cmdinc;
    assign ready_o[1]  = bus_b.req_ready;
    assign gvalid_o[1] = bus_b.grant_valid;
    assign base_o[1]   = bus_b.grant_base;
    assign avail_o[1]  = bus_b.avail;
    assign under_o[1]  = bus_b.underflow;
    assign cmd_o[1]    = bus_b.cmdvalid;
    assign cmdinc_o[1] = bus_b.cmdinc;

    // Reference model: a request is either absent, holding for credit, or being granted;
    // returns are the difference between total units granted and total units handed back.
    int     m_cons      [2];
    int     m_avail     [2];
    int     m_base      [2];
    int     m_len       [2];
    bit     m_under     [2];
    bit     m_holding   [2];
    bit     m_grant_now [2];
    longint m_granted   [2];
    longint m_returned  [2];

    task automatic model_step(int k, int remote_full);
        int d;
        if (rst) begin
            m_cons[k] = 0; m_avail[k] = 0; m_base[k] = 0; m_len[k] = 0;
            m_under[k] = 0; m_holding[k] = 0; m_grant_now[k] = 0;
            m_granted[k] = 0; m_returned[k] = 0;
        end else begin
            d = ((remote_full - m_cons[k]) % 256 + 256) % 256;
            if (m_granted[k] != m_returned[k]) m_returned[k]++;
            if (m_grant_now[k]) begin
                m_grant_now[k] = 0;
            end else if (m_holding[k]) begin
                if (m_avail[k] >= m_len[k]) begin
                    m_base[k]      = m_cons[k];
                    m_cons[k]      = (m_cons[k] + m_len[k]) % 256;
                    m_granted[k]  += m_len[k];
                    m_holding[k]   = 0;
                    m_grant_now[k] = 1;
                end
            end else if (vld[k]) begin
                m_holding[k] = 1;
                m_len[k]     = int'(len_in[k]);
            end
            if (d >= 128) begin
                m_avail[k] = 0;
                m_under[k] = 1;
            end else begin
                m_avail[k] = d;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, int'(remote_a));
        model_step(1, int'(remote_b) * 4);
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Every cycle, every output of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("req_ready[%0d]", k), 32'(ready_o[k]), 32'(m_grant_now[k]));
            checkOutput($sformatf("grant_valid[%0d]", k), 32'(gvalid_o[k]), 32'(m_grant_now[k]));
            checkOutput($sformatf("grant_base[%0d]", k), 32'(base_o[k]), 32'(m_base[k]));
            checkOutput($sformatf("avail[%0d]", k), 32'(avail_o[k]), 32'(m_avail[k]));
            checkOutput($sformatf("underflow[%0d]", k), 32'(under_o[k]), 32'(m_under[k]));
            checkOutput($sformatf("cmdvalid[%0d]", k), 32'(cmd_o[k]),
                        32'(m_granted[k] != m_returned[k]));
            checkOutput($sformatf("cmdinc[%0d]", k), 32'(cmdinc_o[k]), 32'd1);
        end
    end

    task automatic ticks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic requestStart(int k, int len);
        @(negedge clk);
        vld[k]    = 1'b1;
        len_in[k] = 4'(len);
    endtask

    task automatic waitReady(int k, int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ready_o[k]) begin
                seen   = 1'b1;
                vld[k] = 1'b0;
                break;
            end
        end
    endtask

    task automatic applyStimulus(int k, int len, string name);
        bit seen;
        requestStart(k, len);
        waitReady(k, 20, seen);
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    initial begin
        bit seen;
        int bcons;
        vld[0] = 1'b0; vld[1] = 1'b0;
        len_in[0] = '0; len_in[1] = '0;

        // Reset held three cycles with a non-zero producer count
        rst = 1'b1; remote_a = 8'h40;
        ticks(3);
        checkOutput("rst_avail", 32'(avail_o[0]), 32'h0);
        checkOutput("rst_ready", 32'(ready_o[0]), 32'h0);
        checkOutput("rst_cmdinc", 32'(cmdinc_o[0]), 32'h1);
        rst = 1'b0;
        ticks(1);
        checkOutput("rst_release_avail", 32'(avail_o[0]), 32'h40);

        // Basic grant of 3 against a count of 5
        remote_a = 8'd5;
        ticks(2);
        applyStimulus(0, 3, "basic_grant");
        checkOutput("basic_base", 32'(base_o[0]), 32'd0);
        checkOutput("basic_cmd_c2", 32'(cmd_o[0]), 32'd1);
        ticks(1);
        checkOutput("basic_avail_c3", 32'(avail_o[0]), 32'd2);
        checkOutput("basic_cmd_c3", 32'(cmd_o[0]), 32'd1);
        ticks(1);
        checkOutput("basic_cmd_c4", 32'(cmd_o[0]), 32'd1);
        ticks(1);
        checkOutput("basic_cmd_c5", 32'(cmd_o[0]), 32'd0);

        // Stall: 4 requested with only 2 available, then the producer moves ahead
        requestStart(0, 4);
        waitReady(0, 8, seen);
        checkOutput("stall_no_grant", 32'(seen), 32'd0);
        remote_a = 8'd9;
        ticks(1);
        checkOutput("stall_avail", 32'(avail_o[0]), 32'd6);
        waitReady(0, 10, seen);
        checkOutput("stall_grant", 32'(seen), 32'd1);
        checkOutput("stall_base", 32'(base_o[0]), 32'd3);

        // Walk the consumed pointer up to 250, then cross the wrap point
        bcons = 7;
        for (int i = 0; i < 16; i++) begin
            remote_a = 8'(bcons + 15);
            applyStimulus(0, 15, "walk_grant");
            bcons += 15;
        end
        remote_a = 8'(bcons + 3);
        applyStimulus(0, 3, "walk_last");
        remote_a = 8'd3;
        ticks(2);
        checkOutput("wrap_avail", 32'(avail_o[0]), 32'd9);
        applyStimulus(0, 8, "wrap_grant");
        checkOutput("wrap_base", 32'(base_o[0]), 32'd250);
        ticks(1);
        checkOutput("wrap_avail_after", 32'(avail_o[0]), 32'd1);

        // Underflow: producer count falls behind consumed=3
        applyStimulus(0, 1, "uf_setup");
        remote_a = 8'd0;
        ticks(1);
        checkOutput("uf_avail", 32'(avail_o[0]), 32'd0);
        checkOutput("uf_flag", 32'(under_o[0]), 32'd1);
        remote_a = 8'd10;
        ticks(2);
        checkOutput("uf_sticky", 32'(under_o[0]), 32'd1);
        checkOutput("uf_recover_avail", 32'(avail_o[0]), 32'd7);
        rst = 1'b1;
        ticks(1);
        checkOutput("uf_cleared", 32'(under_o[0]), 32'd0);
        rst = 1'b0;

        // Reset while holding for credit, then while returns are pending
        remote_a = 8'd0;
        ticks(2);
        requestStart(0, 5);
        waitReady(0, 4, seen);
        checkOutput("midrst_waiting", 32'(seen), 32'd0);
        rst = 1'b1; vld[0] = 1'b0;
        ticks(1);
        rst = 1'b0;
        remote_a = 8'd15;
        ticks(2);
        applyStimulus(0, 15, "drop_grant");
        checkOutput("drop_cmd_before", 32'(cmd_o[0]), 32'd1);
        ticks(1);
        rst = 1'b1;
        ticks(1);
        checkOutput("drop_cmd_after", 32'(cmd_o[0]), 32'd0);
        rst = 1'b0;
        ticks(2);
        checkOutput("drop_avail", 32'(avail_o[0]), 32'd15);
        applyStimulus(0, 5, "represent_grant");
        checkOutput("represent_base", 32'(base_o[0]), 32'd0);

        // Coarse instance: one remote step is four units
        remote_b = 6'd1;
        ticks(2);
        checkOutput("skip_avail", 32'(avail_o[1]), 32'd4);
        applyStimulus(1, 4, "skip_grant4");
        checkOutput("skip_base4", 32'(base_o[1]), 32'd0);
        ticks(5);
        checkOutput("skip_drained", 32'(cmd_o[1]), 32'd0);
        applyStimulus(1, 0, "skip_grant0");
        checkOutput("skip_len0_cmd", 32'(cmd_o[1]), 32'd0);
        checkOutput("skip_base0", 32'(base_o[1]), 32'd4);
        ticks(1);
        checkOutput("skip_len0_cmd_next", 32'(cmd_o[1]), 32'd0);
        requestStart(1, 5);
        waitReady(1, 6, seen);
        checkOutput("skip_len5_waits", 32'(seen), 32'd0);
        remote_b = 6'd3;
        waitReady(1, 10, seen);
        checkOutput("skip_len5_grant", 32'(seen), 32'd1);
        checkOutput("skip_base5", 32'(base_o[1]), 32'd4);

        ticks(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
